// File: rtl/pipeline_ctrl_if.sv
// Hazard/event inputs and stage-register controls between the
// pipeline controller and the datapath.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use_stall;
  logic             branch_taken;
  logic             ex_is_muldiv;
  logic             md_done;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             md_start;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  load_use_stall, branch_taken, ex_is_muldiv,
    input  md_done, mem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush,
    output id_ex_en, id_ex_flush,
    output ex_mem_en, ex_mem_flush, mem_wb_flush,
    output md_start, md_timeout, stall_cycles
  );

  modport slave (
    output load_use_stall, branch_taken, ex_is_muldiv,
    output md_done, mem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush,
    input  id_ex_en, id_ex_flush,
    input  ex_mem_en, ex_mem_flush, mem_wb_flush,
    input  md_start, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, including the
// multi-cycle muldiv wait with timeout and a stall-cycle counter.
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.master bus
);
  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

  localparam logic [1:0] RUN          = 2'd0;
  localparam logic [1:0] MD_WAIT      = 2'd1;
  localparam logic [1:0] MD_DONE_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             md_done_q, md_done_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_q;

  logic dmem_stall;
  logic freeze;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush;
  logic ex_mem_flush, mem_wb_flush;
  logic md_start;

  assign dmem_stall = bus.mem_req & ~bus.dmem_ready;

  always_comb begin
    state_d      = state_q;
    md_done_d    = md_done_q;
    tmo_cnt_d    = tmo_cnt_q;
    md_timeout_d = md_timeout_q;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    md_start     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!dmem_stall) begin
          if (bus.ex_is_muldiv) begin
            freeze    = 1'b1;
            md_start  = 1'b1;
            state_d   = MD_WAIT;
            tmo_cnt_d = '0;
          end else if (bus.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.load_use_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      MD_WAIT: begin
        // saturates so a timeout blocked by dmem fires once memory frees
        if (tmo_cnt_q != TMO_LAST)
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (dmem_stall) begin
          if (bus.md_done) begin
            md_done_d = 1'b1;
            state_d   = MD_DONE_HOLD;
          end
        end else if (bus.md_done) begin
          state_d = RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d      = RUN;
          md_timeout_d = 1'b1;
        end else begin
          freeze = 1'b1;
        end
      end
      MD_DONE_HOLD: begin
        if (!dmem_stall && md_done_q) begin
          state_d   = RUN;
          md_done_d = 1'b0;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b1;
    end

    if (dmem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b1;
      md_start     = 1'b0;
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      md_start     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      md_done_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      md_timeout_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      md_done_q    <= md_done_d;
      tmo_cnt_q    <= tmo_cnt_d;
      md_timeout_q <= md_timeout_d;
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.md_start     = md_start;
  assign bus.md_timeout   = md_timeout_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Vector table, directed muldiv sequences and a random run against
// a behavioural model of the pipeline controller.
module tb_pipeline_ctrl;
  localparam int     TMO     = 8;
  localparam int     SAT_W   = 4;
  localparam longint SAT_MAX = 15;

  localparam int A_RESET  = 0;
  localparam int A_MEM    = 1;
  localparam int A_FREEZE = 2;
  localparam int A_ISSUE  = 3;
  localparam int A_ADV    = 4;
  localparam int A_BRANCH = 5;
  localparam int A_BUBBLE = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32))    pif ();
  pipeline_ctrl_if #(.CNT_W(SAT_W)) sif ();

  assign sif.load_use_stall = pif.load_use_stall;
  assign sif.branch_taken   = pif.branch_taken;
  assign sif.ex_is_muldiv   = pif.ex_is_muldiv;
  assign sif.md_done        = pif.md_done;
  assign sif.mem_req        = pif.mem_req;
  assign sif.dmem_ready     = pif.dmem_ready;

  pipeline_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.master)
  );

  pipeline_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(SAT_W)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  int n_chk;
  int n_fail;
  int starts;

  bit     m_busy;
  bit     m_ready;
  bit     m_tmo;
  int     m_wait;
  longint m_stalls;
  int     cur;

  typedef struct {
    bit         r, lu, br, md, dn, mr, dr;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {pif.pc_en, pif.if_id_en, pif.if_id_flush,
            pif.id_ex_en, pif.id_ex_flush,
            pif.ex_mem_en, pif.ex_mem_flush,
            pif.mem_wb_flush, pif.md_start};
  endfunction

  // {pc,if_id en,flush,id_ex en,flush,ex_mem en,flush,mem_wb flush,start}
  function automatic logic [8:0] act_vec(input int a);
    case (a)
      A_RESET:  return 9'b001010110;
      A_MEM:    return 9'b000000010;
      A_FREEZE: return 9'b000000100;
      A_ISSUE:  return 9'b000000101;
      A_BRANCH: return 9'b111111000;
      A_BUBBLE: return 9'b000111000;
      default:  return 9'b110101000;
    endcase
  endfunction

  function automatic int cur_act();
    if (!rst_n) return A_RESET;
    if (pif.mem_req && !pif.dmem_ready) return A_MEM;
    if (m_ready) return A_ADV;
    if (m_busy)
      return (pif.md_done || m_wait == TMO - 1) ? A_ADV : A_FREEZE;
    if (pif.ex_is_muldiv) return A_ISSUE;
    if (pif.branch_taken) return A_BRANCH;
    if (pif.load_use_stall) return A_BUBBLE;
    return A_ADV;
  endfunction

  task automatic drive(input bit r, lu, br, md, dn, mr, dr);
    rst_n              = r;
    pif.load_use_stall = lu;
    pif.branch_taken   = br;
    pif.ex_is_muldiv   = md;
    pif.md_done        = dn;
    pif.mem_req        = mr;
    pif.dmem_ready     = dr;
  endtask

  task automatic sample();
    longint sat;
    @(negedge clk);
    cur = cur_act();
    sat = (m_stalls > SAT_MAX) ? SAT_MAX : m_stalls;
    chk("outs", 64'(dut_vec()), 64'(act_vec(cur)));
    chk("md_timeout", 64'(pif.md_timeout), 64'(m_tmo));
    chk("stall_cycles", 64'(pif.stall_cycles), m_stalls);
    chk("stall_sat", 64'(sif.stall_cycles), sat);
    if (pif.md_start === 1'b1) starts++;
  endtask

  task automatic advance();
    logic [8:0] v;
    bit ms;
    v  = act_vec(cur);
    ms = pif.mem_req && !pif.dmem_ready;
    if (!rst_n) begin
      m_busy   = 0;
      m_ready  = 0;
      m_wait   = 0;
      m_tmo    = 0;
      m_stalls = 0;
    end else begin
      if (!v[8]) m_stalls++;
      if (m_ready) begin
        if (!ms) m_ready = 0;
      end else if (m_busy) begin
        if (ms) begin
          if (pif.md_done) begin
            m_busy  = 0;
            m_ready = 1;
          end else if (m_wait < TMO - 1) begin
            m_wait++;
          end
        end else if (pif.md_done) begin
          m_busy = 0;
        end else if (m_wait == TMO - 1) begin
          m_busy = 0;
          m_tmo  = 1;
        end else begin
          m_wait++;
        end
      end else if (cur == A_ISSUE) begin
        m_busy = 1;
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    starts = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    starts = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    m_busy   = 0;
    m_ready  = 0;
    m_wait   = 0;
    m_tmo    = 0;
    m_stalls = 0;

    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 9'b001010110});
    tbl.push_back('{0, 1, 1, 1, 1, 1, 0, 9'b001010110});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 9'b110101000});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 9'b000111000});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 9'b111111000});
    tbl.push_back('{1, 1, 1, 0, 0, 0, 1, 9'b111111000});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 1, 9'b110101000});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 0, 9'b000000010});
    tbl.push_back('{1, 1, 1, 0, 0, 1, 0, 9'b000000010});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 9'b110101000});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 9'b110101000});
    tbl.push_back('{1, 0, 0, 1, 0, 1, 0, 9'b000000010});
    tbl.push_back('{1, 1, 1, 1, 0, 0, 1, 9'b000000101});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 1, 9'b000000100});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 9'b001010110});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].lu, tbl[i].br, tbl[i].md,
            tbl[i].dn, tbl[i].mr, tbl[i].dr);
      sample();
      chk($sformatf("tbl%0d", i), 64'(dut_vec()), 64'(tbl[i].exp));
      advance();
    end

    // load-use then branch+load-use
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 1);
    tick();
    idle();
    sample();
    chk("lu_stall", 64'(pif.stall_cycles), 64'd1);
    advance();
    drive(1, 1, 1, 0, 0, 0, 1);
    sample();
    chk("br_lu", 64'(dut_vec()), 64'(9'b111111000));
    advance();
    idle();
    sample();
    chk("br_lu_stall", 64'(pif.stall_cycles), 64'd1);
    advance();

    // muldiv completing after 5 frozen cycles
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 1);
    sample();
    chk("A_issue", 64'(dut_vec()), 64'(9'b000000101));
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 0, 1);
      sample();
      chk("A_frozen", 64'(dut_vec()), 64'(9'b000000100));
      advance();
    end
    drive(1, 0, 0, 1, 1, 0, 1);
    sample();
    chk("A_release", 64'(dut_vec()), 64'(9'b110101000));
    advance();
    idle();
    sample();
    chk("A_run", 64'(dut_vec()), 64'(9'b110101000));
    chk("A_stalls", 64'(pif.stall_cycles), 64'd6);
    chk("A_starts", 64'(starts), 64'd1);
    advance();

    // md_done during a 3-cycle dmem stall
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, 0, 0, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, i != 2, 1, 0);
      sample();
      chk("B_memhold", 64'(dut_vec()), 64'(9'b000000010));
      advance();
    end
    drive(1, 0, 0, 1, 0, 1, 1);
    sample();
    chk("B_release", 64'(dut_vec()), 64'(9'b110101000));
    advance();
    idle();
    sample();
    chk("B_run", 64'(dut_vec()), 64'(9'b110101000));
    chk("B_stalls", 64'(pif.stall_cycles), 64'd6);
    chk("B_starts", 64'(starts), 64'd1);
    advance();

    // timeout with no md_done
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 1);
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      drive(1, 0, 0, 1, 0, 0, 1);
      sample();
      chk("C_frozen", 64'(dut_vec()), 64'(9'b000000100));
      chk("C_no_tmo", 64'(pif.md_timeout), 64'd0);
      advance();
    end
    drive(1, 0, 0, 1, 0, 0, 1);
    sample();
    chk("C_release", 64'(dut_vec()), 64'(9'b110101000));
    advance();
    for (int i = 0; i < 4; i++) begin
      idle();
      sample();
      chk("C_tmo_sticky", 64'(pif.md_timeout), 64'd1);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    sample();
    chk("C_tmo_clr", 64'(pif.md_timeout), 64'd0);
    advance();

    // reset in the middle of a muldiv wait
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1, 1, 0, 1);
    sample();
    chk("D_rst_outs", 64'(dut_vec()), 64'(9'b001010110));
    advance();
    idle();
    sample();
    chk("D_run", 64'(dut_vec()), 64'(9'b110101000));
    chk("D_stalls", 64'(pif.stall_cycles), 64'd0);
    chk("D_tmo", 64'(pif.md_timeout), 64'd0);
    advance();

    // stall counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      tick();
    end
    idle();
    sample();
    chk("E_sat", 64'(sif.stall_cycles), 64'd15);
    chk("E_main", 64'(pif.stall_cycles), 64'd20);
    advance();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) != 0,
            $urandom_range(3) == 0,
            $urandom_range(4) == 0,
            $urandom_range(5) == 0,
            $urandom_range(4) == 0,
            $urandom_range(2) == 0,
            $urandom_range(3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, the maximum number of MD_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the stall-cycle counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have inputs load_use_stall (1, hazard unit), branch_taken (1, EX redirect), ex_is_muldiv (1, EX holds a multi-cycle op), md_done (1, one-cycle unit completion pulse), mem_req (1, MEM accessing dmem) and dmem_ready (1).
REQ-006 SHALL have 1-bit outputs pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush, md_start and md_timeout (sticky), plus stall_cycles [CNT_W-1:0].
REQ-007 A flush output SHALL dominate its matching enable: the stage register loads a bubble.

Function
REQ-008 SHALL implement a state machine with states RUN, MD_WAIT and MD_DONE_HOLD, plus registers md_done_q, tmo_cnt (ceil(log2(MD_TIMEOUT+1)) bits), md_timeout and stall_cycles.
REQ-009 dmem_stall = mem_req & ~dmem_ready SHALL take priority in every state: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, all other flushes 0, md_start=0.
REQ-010 In RUN with no dmem_stall and ex_is_muldiv=1, the block SHALL assert md_start for exactly one cycle with pc/if_id/id_ex/ex_mem enables 0 and ex_mem_flush=1, then go to MD_WAIT next cycle with tmo_cnt cleared.
REQ-011 In RUN, ex_is_muldiv=1 SHALL override branch_taken and load_use_stall in the same cycle.
REQ-012 In RUN, branch_taken=1 (with no dmem_stall and no muldiv) SHALL give pc_en=1, if_id_flush=1, id_ex_flush=1 and all enables 1; load_use_stall is ignored.
REQ-013 In RUN, load_use_stall=1 alone SHALL give pc_en=0, if_id_en=0, id_ex_flush=1 and ex_mem_en=1.
REQ-014 In RUN with no event, all enables SHALL be 1 and all flushes 0.
REQ-015 In MD_WAIT, pc/if_id/id_ex/ex_mem enables SHALL be 0, ex_mem_flush=1, md_start=0 and tmo_cnt SHALL increment each cycle.
REQ-016 md_done in MD_WAIT with no dmem_stall SHALL give that cycle all enables 1 and ex_mem_flush=0 (EX/MEM captures the result), then return to RUN.
REQ-017 md_done in MD_WAIT while dmem_stall=1 SHALL set md_done_q and go to MD_DONE_HOLD.
REQ-018 MD_DONE_HOLD SHALL keep the freeze of REQ-015 (no tmo_cnt increment) until dmem_stall=0, then behave as REQ-016, clear md_done_q and return to RUN.
REQ-019 When tmo_cnt reaches MD_TIMEOUT-1 in MD_WAIT without md_done, the block SHALL set md_timeout=1 (sticky), release the pipeline as in REQ-016 and return to RUN.
REQ-020 md_done SHALL be ignored in RUN and MD_DONE_HOLD.
REQ-021 stall_cycles SHALL increment by 1 on each cycle with rst_n=1 and pc_en=0, saturating at all-ones.
REQ-022 The instruction returning from MD_WAIT/MD_DONE_HOLD to RUN SHALL NOT re-issue md_start: id_ex_en=1 on the release cycle advances EX.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL load state RUN, md_done_q=0, tmo_cnt=0, md_timeout=0 and stall_cycles=0.
REQ-024 While rst_n=0, outputs SHALL be all enables 0, all flushes 1 and md_start=0, overriding every input.
REQ-025 Reset asserted in MD_WAIT or MD_DONE_HOLD SHALL abandon the operation with no md_start and no md_timeout.

Verification
REQ-026 Load-use: load_use_stall=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle, stall_cycles +1.
REQ-027 Branch plus load-use simultaneously -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cycles unchanged.
REQ-028 Muldiv: ex_is_muldiv=1, md_done 5 cycles after md_start -> md_start high exactly 1 cycle, 5 frozen cycles after issue, release cycle with ex_mem_flush=0, back to RUN, stall_cycles +6.
REQ-029 md_done while mem_req=1 and dmem_ready=0 for 3 cycles -> MD_DONE_HOLD, release on the first cycle dmem_ready=1, single md_start total.
REQ-030 Timeout with MD_TIMEOUT=8 and no md_done -> md_timeout=1 after 8 MD_WAIT cycles, pipeline released, md_timeout held until rst_n=0.
REQ-031 Reset mid-MD_WAIT: rst_n=0 for 1 cycle -> state RUN, stall_cycles=0, md_timeout=0, enables 1 on the first cycle after rst_n=1 with idle inputs.
